req_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream request/acknowledge port among N requesters using a four-phase level handshake. Each requester holds `ireq` high until it sees its `oack`, then drops it. The arbiter grants one requester at a time, drives the shared `oreq` with the owner's index on `oreq_id`, and returns the downstream `ack` as that owner's `oack`. It sits between the event-processing cores and a single shared request resource, such as the memory or queue request port.

---
 rtl/req_arbiter.sv | 132 +++++++++++++
 tb/tb_req_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter.sv
// req_arbiter
//   Round-robin arbiter that shares one downstream four-phase request/ack
//   port among N requesters. A requester holds ireq[i] high until its
//   oack[i] rises, then drops it. Only one grant is in flight at a time.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   ireq[N]    per-requester request levels
//   oack[N]    per-requester completion levels (one-hot or zero)
//   oreq       shared downstream request
//   oreq_id    index of the current owner
//   ack        downstream acknowledge
//   busy       high whenever a grant is in progress
//   grant_cnt  number of completed grants (wraps at 16 bits)
module req_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    ireq,
    output logic [N-1:0]    oack,
    output logic            oreq,
    output logic [ID_W-1:0] oreq_id,
    input  logic            ack,
    output logic            busy,
    output logic [15:0]     grant_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]     grant_cnt_q, grant_cnt_d;

    logic            pick_valid;
    logic [ID_W-1:0] pick_id;
    logic            owner_req;
    logic [ID_W-1:0] owner_next;

    // Scan rr_ptr, rr_ptr+1, ... mod N and take the first pending request.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!pick_valid && ((ireq & (N'(1) << idx)) != '0)) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        owner_req = (ireq & (N'(1) << owner_q)) != '0;
        // (owner + 1) mod N; with N = 1 this is always 0.
        if (32'(owner_q) + 32'd1 >= N) begin
            owner_next = '0;
        end else begin
            owner_next = owner_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        grant_cnt_d = grant_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_id;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A started grant always completes, whatever ireq does.
                if (ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!owner_req) begin
                    state_d     = IDLE;
                    rr_ptr_d    = owner_next;
                    grant_cnt_d = grant_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            grant_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    // Moore outputs, decoded from registered state only.
    always_comb begin
        oreq      = (state_q == REQ);
        busy      = (state_q != IDLE);
        oreq_id   = owner_q;
        grant_cnt = grant_cnt_q;
        oack      = '0;
        if (state_q == DONE) begin
            oack = N'(1) << owner_q;
        end
    end

endmodule

// File: tb/tb_req_arbiter.sv
module tb_req_arbiter;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    ireq = '0;
    logic [N-1:0]    oack;
    logic            oreq;
    logic [ID_W-1:0] oreq_id;
    logic            ack = 1'b0;
    logic            busy;
    logic [15:0]     grant_cnt;

    int errors = 0;
    int checks = 0;
    logic preload = 1'b0;

    req_arbiter #(.N(N), .ID_W(ID_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .ireq      (ireq),
        .oack      (oack),
        .oreq      (oreq),
        .oreq_id   (oreq_id),
        .ack       (ack),
        .busy      (busy),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = request out, 2 = acked.
    int              m_phase = 0;
    logic [ID_W-1:0] m_owner = '0;
    logic [ID_W-1:0] m_ptr = '0;
    logic [15:0]     m_cnt = '0;

    always @(posedge clk) begin
        logic found;
        int idx;
        logic [N-1:0] exp_oack;
        if (preload) m_cnt = 16'hFFFF;
        if (reset) begin
            m_phase = 0;
            m_owner = '0;
            m_ptr   = '0;
            m_cnt   = '0;
        end else if (m_phase == 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (int'(m_ptr) + k) % N;
                if (!found && ((ireq & (N'(1) << idx)) != '0)) begin
                    found   = 1'b1;
                    m_owner = ID_W'(idx);
                end
            end
            if (found) m_phase = 1;
        end else if (m_phase == 1) begin
            if (ack) m_phase = 2;
        end else begin
            if ((ireq & (N'(1) << m_owner)) == '0) begin
                m_phase = 0;
                m_ptr   = ID_W'((int'(m_owner) + 1) % N);
                m_cnt   = m_cnt + 16'd1;
            end
        end
        exp_oack = (m_phase == 2) ? (N'(1) << m_owner) : '0;
        #1;
        check("model_oreq", 32'(oreq), 32'(m_phase == 1));
        check("model_busy", 32'(busy), 32'(m_phase != 0));
        check("model_oack", 32'(oack), 32'(exp_oack));
        check("model_cnt", 32'(grant_cnt), 32'(m_cnt));
        if (m_phase != 0) check("model_id", 32'(oreq_id), 32'(m_owner));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ireq  = '0;
        ack   = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int q_ids[$];
        int cycles;
        logic started;
        logic prev_oreq;

        // Reset with everything asserted.
        reset = 1'b1;
        ireq  = 4'b1111;
        ack   = 1'b1;
        tick();
        check("rst_oreq", 32'(oreq), 0);
        check("rst_oack", 32'(oack), 0);
        tick();
        check("rst_all", {oreq, busy, oack, oreq_id, grant_cnt}, 0);
        reset = 1'b0;
        ack   = 1'b0;
        tick();
        check("first_id", 32'(oreq_id), 0);
        check("first_oreq", 32'(oreq), 1);
        ack = 1'b1;
        tick();
        ireq = '0;
        ack  = 1'b0;
        tick();

        // Single requester.
        do_reset();
        ireq = 4'b0100;
        tick();
        check("single_oreq", 32'(oreq), 1);
        check("single_id", 32'(oreq_id), 2);
        tick();
        tick();
        check("single_wait", 32'(oreq), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("single_oack", 32'(oack), 32'h4);
        check("single_oreq_low", 32'(oreq), 0);
        tick();
        tick();
        check("single_hold", 32'(oack), 32'h4);
        ireq = '0;
        tick();
        check("single_rel", 32'(oack), 0);
        check("single_cnt", 32'(grant_cnt), 1);

        // Pointer now 3: 0011 wraps to id 0 first, then id 1.
        ireq = 4'b0011;
        tick();
        check("wrap_first", 32'(oreq_id), 0);
        ack = 1'b1;
        tick();
        check("wrap_oack0", 32'(oack), 32'h1);
        ireq = 4'b0010;
        ack  = 1'b0;
        tick();
        check("wrap_idle", 32'(busy), 0);
        tick();
        check("wrap_second", 32'(oreq_id), 1);
        ack = 1'b1;
        tick();
        ireq = '0;
        ack  = 1'b0;
        tick();
        check("wrap_cnt", 32'(grant_cnt), 3);

        // ack in IDLE ignored; owner dropping during REQ still completes.
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("idle_ack", 32'(busy), 0);
        ireq = 4'b0001;
        tick();
        ireq = '0;
        tick();
        check("drop_in_req", 32'(oreq), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("drop_pulse", 32'(oack), 32'h1);
        tick();
        check("drop_done", 32'(oack), 0);
        check("drop_cnt", 32'(grant_cnt), 4);

        // Fairness: all requesters keep asking, ack immediately.
        do_reset();
        started   = 1'b0;
        prev_oreq = 1'b0;
        cycles    = 0;
        ireq      = 4'b1111;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (oreq) started = 1'b1;
            if (started) cycles++;
            if (oreq && !prev_oreq) q_ids.push_back(int'(oreq_id));
            prev_oreq = oreq;
            if (grant_cnt == 16'd6) break;
            ireq = ~oack;
            ack  = oreq;
        end
        ireq = '0;
        ack  = 1'b0;
        check("rr_cnt", 32'(grant_cnt), 6);
        check("rr_cycles", 32'(cycles), 18);
        check("rr_ngrants", 32'(q_ids.size()), 6);
        if (q_ids.size() == 6) begin
            check("rr_order", 32'({q_ids[0][3:0], q_ids[1][3:0], q_ids[2][3:0],
                                   q_ids[3][3:0], q_ids[4][3:0], q_ids[5][3:0]}),
                  32'h012301);
        end

        // Reset mid-grant.
        tick();
        ireq = 4'b0010;
        tick();
        check("mid_oreq", 32'(oreq), 1);
        reset = 1'b1;
        tick();
        check("mid_reset_oreq", 32'(oreq), 0);
        check("mid_reset_cnt", 32'(grant_cnt), 0);
        reset = 1'b0;
        ireq  = '0;
        tick();

        // Counter wrap from a preloaded value.
        preload = 1'b1;
        force dut.grant_cnt_q = 16'hFFFF;
        tick();
        check("preload_cnt", 32'(grant_cnt), 32'hFFFF);
        release dut.grant_cnt_q;
        preload = 1'b0;
        ireq = 4'b1000;
        tick();
        ack = 1'b1;
        tick();
        ireq = '0;
        ack  = 1'b0;
        tick();
        check("wrap_to_zero", 32'(grant_cnt), 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                logic [N-1:0] m;
                m = N'(1) << i;
                if ((oack & m) != '0) begin
                    if ($urandom_range(3) != 0) ireq = ireq & ~m;
                end else if ((ireq & m) == '0) begin
                    if ($urandom_range(2) == 0) ireq = ireq | m;
                end else if (oreq && int'(oreq_id) == i && $urandom_range(15) == 0) begin
                    ireq = ireq & ~m;
                end
            end
            ack   = ($urandom_range(2) == 0);
            reset = ($urandom_range(199) == 0);
        end
        reset = 1'b0;
        ireq  = '0;
        ack   = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
